gen_control: RTL



---
 rtl/gen_control.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/gen_control.sv
// Control stage ahead of the pattern-load/process sequencer: turns raw load, run/pause and step
// buttons into the sequencer's enb/run/trigger strobes, paces RUNNING and counts generations.
module gen_control #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 2500000,
  parameter int LOAD_CYCLES     = 13,
  parameter int GEN_BITS        = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_load,
  input  logic                btn_run,
  input  logic                btn_step,
  output logic                enb,
  output logic                run,
  output logic                trigger,
  output logic                busy,
  output logic                running,
  output logic [GEN_BITS-1:0] gen_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int HOLD_W = $clog2(LOAD_CYCLES + 2);

  localparam int EV_LOAD = 0;
  localparam int EV_RUN  = 1;
  localparam int EV_STEP = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOADING,
    S_PAUSED,
    S_RUNNING
  } state_e;

  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_step, btn_run, btn_load};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic            sync1_q, sync2_q;
    logic            level_q, level_prev_q;
    logic            press_q;
    logic [DB_W-1:0] cnt_q;

    // NOTE: every register here updates with <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
        press_q      <= 1'b0;
        cnt_q        <= '0;
      end else begin
        sync1_q      <= btn_raw[b];
        sync2_q      <= sync1_q;
        level_prev_q <= level_q;
        press_q      <= level_q & ~level_prev_q;
        if (sync2_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + DB_W'(1);
        end
      end
    end

    assign press[b] = press_q;
  end

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [GEN_BITS-1:0] gen_q, gen_d;
  logic                enb_q, enb_d;
  logic                run_q, run_d;
  logic                trigger_q, trigger_d;
  logic                busy_q, busy_d;
  logic                running_q, running_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      tick_q    <= '0;
      gen_q     <= '0;
      enb_q     <= 1'b0;
      run_q     <= 1'b0;
      trigger_q <= 1'b0;
      busy_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      tick_q    <= tick_d;
      gen_q     <= gen_d;
      enb_q     <= enb_d;
      run_q     <= run_d;
      trigger_q <= trigger_d;
      busy_q    <= busy_d;
      running_q <= running_d;
    end
  end

  // NOTE: every *_d gets a default before the case, so no path can leave one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    tick_d    = tick_q;
    gen_d     = gen_q;
    enb_d     = 1'b0;
    run_d     = 1'b0;
    trigger_d = 1'b0;
    busy_d    = 1'b0;
    running_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (press[EV_LOAD]) begin
          state_d = S_LOADING;
          enb_d   = 1'b1;
          busy_d  = 1'b1;
          gen_d   = '0;
          hold_d  = HOLD_W'(LOAD_CYCLES + 1);
        end
      end
      S_LOADING: begin
        // Presses are dropped here: a trigger with run high would abort the write sequence.
        busy_d = 1'b1;
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q <= HOLD_W'(1)) begin
          state_d = S_PAUSED;
          busy_d  = 1'b0;
        end
      end
      S_PAUSED: begin
        if (press[EV_LOAD]) begin
          state_d = S_LOADING;
          enb_d   = 1'b1;
          busy_d  = 1'b1;
          gen_d   = '0;
          hold_d  = HOLD_W'(LOAD_CYCLES + 1);
        end else if (press[EV_RUN]) begin
          state_d   = S_RUNNING;
          tick_d    = TICK_W'(TICK_DIV - 1);
          run_d     = 1'b1;
          running_d = 1'b1;
        end else if (press[EV_STEP]) begin
          trigger_d = 1'b1;
          run_d     = 1'b1;
          gen_d     = gen_q + GEN_BITS'(1);
        end
      end
      S_RUNNING: begin
        run_d     = 1'b1;
        running_d = 1'b1;
        if (press[EV_LOAD]) begin
          state_d   = S_LOADING;
          enb_d     = 1'b1;
          busy_d    = 1'b1;
          gen_d     = '0;
          hold_d    = HOLD_W'(LOAD_CYCLES + 1);
          run_d     = 1'b0;
          running_d = 1'b0;
        end else if (press[EV_RUN]) begin
          state_d   = S_PAUSED;
          run_d     = 1'b0;
          running_d = 1'b0;
        end else if (tick_q == '0) begin
          trigger_d = 1'b1;
          gen_d     = gen_q + GEN_BITS'(1);
          tick_d    = TICK_W'(TICK_DIV - 1);
        end else begin
          tick_d = tick_q - TICK_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign enb       = enb_q;
  assign run       = run_q;
  assign trigger   = trigger_q;
  assign busy      = busy_q;
  assign running   = running_q;
  assign gen_count = gen_q;

endmodule
